// File: rtl/kuznechik_cipher_arbiter.sv
// kuznechik_cipher_arbiter
// Round-robin scheduler sharing one kuznechik_cipher core between two
// 128-bit block requesters. Owns the core request/ack handshake, latches
// plaintext and ciphertext, and routes each result back to its issuer.
// Optional feature macro: KUZNECHIK_ARB_TIMEOUT_EN enables a WAIT-state
// watchdog of TIMEOUT_CYCLES cycles that returns an error response.
module kuznechik_cipher_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req0_valid_i,
    input  logic [127:0] req0_data_i,
    output logic         req0_ready_o,
    input  logic         req1_valid_i,
    input  logic [127:0] req1_data_i,
    output logic         req1_ready_o,
    output logic         rsp0_valid_o,
    input  logic         rsp0_ready_i,
    output logic         rsp1_valid_o,
    input  logic         rsp1_ready_i,
    output logic [127:0] rsp_data_o,
    output logic         rsp_err_o,
    output logic         cipher_req_o,
    output logic         cipher_ack_o,
    output logic [127:0] cipher_data_o,
    input  logic         cipher_busy_i,
    input  logic         cipher_valid_i,
    input  logic [127:0] cipher_data_i,
    output logic         busy_o,
    output logic         owner_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ACK
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   res_q, res_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic           gnt0, gnt1;

`ifdef KUZNECHIK_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Grant selection: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        gnt0 = req0_valid_i & (~req1_valid_i | last_q);
        gnt1 = req1_valid_i & (~req0_valid_i | ~last_q);
    end

    // Next-state and output decode; cipher_busy_i is informational and never steers the FSM
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        res_d         = res_q;
        owner_d       = owner_q;
        last_d        = last_q;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        rsp0_valid_o  = 1'b0;
        rsp1_valid_o  = 1'b0;
        rsp_data_o    = '0;
        rsp_err_o     = 1'b0;
        cipher_req_o  = 1'b0;
        cipher_ack_o  = 1'b0;
        cipher_data_o = (state_q != IDLE) ? blk_q : '0;
        busy_o        = (state_q != IDLE);
        owner_o       = owner_q;
`ifdef KUZNECHIK_ARB_TIMEOUT_EN
        cnt_d         = '0;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                req0_ready_o = gnt0;
                req1_ready_o = gnt1;
                if (gnt0) begin
                    blk_d   = req0_data_i;
                    owner_d = 1'b0;
                    state_d = ISSUE;
                end else if (gnt1) begin
                    blk_d   = req1_data_i;
                    owner_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cipher_req_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cipher_valid_i) begin
                    res_d   = cipher_data_i;
`ifdef KUZNECHIK_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef KUZNECHIK_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rsp0_valid_o = ~owner_q;
                rsp1_valid_o = owner_q;
                rsp_data_o   = res_q;
`ifdef KUZNECHIK_ARB_TIMEOUT_EN
                rsp_err_o    = err_q;
`endif
                if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
                    last_d  = owner_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                cipher_ack_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; last-served pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            blk_q   <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef KUZNECHIK_ARB_TIMEOUT_EN
    // Watchdog counter and error flag for the WAIT state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_kuznechik_cipher_arbiter.sv
// tb_kuznechik_cipher_arbiter
// Self-checking bench: stub cipher core with programmable latency, a
// scoreboard of expected responses filled on each request handshake, a
// vector table of round-robin scenarios and hand-written corner cases.
module tb_kuznechik_cipher_arbiter;

   localparam int TO_CYCLES = 8;
   localparam logic [127:0] PT   = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [127:0] CT   = 128'h7f679d90bebc24305a468d42b9d4edcd;
   localparam logic [127:0] MASK = PT ^ CT;

   logic         clk_i = 1'b0;
   logic         rstn_i = 1'b0;
   logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
   logic [127:0] req0_data_i = '0, req1_data_i = '0;
   logic         req0_ready_o, req1_ready_o;
   logic         rsp0_valid_o, rsp1_valid_o;
   logic         rsp0_ready_i = 1'b1, rsp1_ready_i = 1'b1;
   logic [127:0] rsp_data_o;
   logic         rsp_err_o;
   logic         cipher_req_o, cipher_ack_o;
   logic [127:0] cipher_data_o;
   logic         cipher_busy_i, cipher_valid_i;
   logic [127:0] cipher_data_i;
   logic         busy_o, owner_o;

   kuznechik_cipher_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .cipher_req_o(cipher_req_o), .cipher_ack_o(cipher_ack_o), .cipher_data_o(cipher_data_o),
      .cipher_busy_i(cipher_busy_i), .cipher_valid_i(cipher_valid_i), .cipher_data_i(cipher_data_i),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   // Free-running clock and cycle counter
   always #5 clk_i = ~clk_i;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Stand-in for the real core: the standard-key vector maps PT to CT
   function automatic logic [127:0] coreModel(input logic [127:0] x);
      return x ^ MASK;
   endfunction

   // Stub core: valid appears stub_lat cycles after the request pulse and holds until ack
   int           stub_lat = 3;
   logic         stub_never = 1'b0;
   logic         stub_pend;
   int           stub_cnt;
   logic [127:0] stub_res;
   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stub_pend <= 1'b0;
         stub_cnt  <= 0;
         stub_res  <= '0;
      end else if (cipher_req_o) begin
         stub_pend <= 1'b1;
         stub_cnt  <= stub_lat - 1;
         stub_res  <= coreModel(cipher_data_o);
      end else if (stub_pend && cipher_ack_o) begin
         stub_pend <= 1'b0;
      end else if (stub_pend && stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
      end
   end
   assign cipher_valid_i = stub_pend && (stub_cnt == 0) && !stub_never;
   assign cipher_data_i  = cipher_valid_i ? stub_res : ~stub_res;
   assign cipher_busy_i  = stub_pend && !cipher_valid_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         owner;
      logic         err;
      logic [127:0] data;
   } exp_t;

   exp_t sb[$];
   logic served_q[$];
   int   req_pulses = 0, ack_pulses = 0;
   int   last_req_cyc = 0, last_ack_cyc = 0, rsp_rise_cyc = 0;
   logic rsp1_seen = 1'b0;
   logic prev_rsp_any = 1'b0;
   logic [127:0] last_rsp_data = '0;

   task automatic popCheck(input logic who);
      exp_t e;
      checkOutput("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("rsp_owner", who, e.owner);
         checkOutput("rsp_data", rsp_data_o, e.data);
         checkOutput("rsp_err", rsp_err_o, e.err);
         served_q.push_back(who);
         last_rsp_data = rsp_data_o;
      end
   endtask

   // Monitor: push expectations on request handshakes, pop and compare on response handshakes
   always @(negedge clk_i) begin
      exp_t e;
      logic rsp_any;
      if (!rstn_i) begin
         prev_rsp_any = 1'b0;
      end else begin
         if (req0_valid_i && req0_ready_o) begin
            e.owner = 1'b0; e.err = stub_never;
            e.data  = stub_never ? '0 : coreModel(req0_data_i);
            sb.push_back(e);
         end
         if (req1_valid_i && req1_ready_o) begin
            e.owner = 1'b1; e.err = stub_never;
            e.data  = stub_never ? '0 : coreModel(req1_data_i);
            sb.push_back(e);
         end
         if (cipher_req_o) begin req_pulses++; last_req_cyc = cyc; end
         if (cipher_ack_o) begin ack_pulses++; last_ack_cyc = cyc; end
         if (rsp1_valid_o) rsp1_seen = 1'b1;
         rsp_any = rsp0_valid_o | rsp1_valid_o;
         if (rsp_any && !prev_rsp_any) rsp_rise_cyc = cyc;
         prev_rsp_any = rsp_any;
         if (rsp_any) checkOutput("rsp_onehot", rsp0_valid_o & rsp1_valid_o, 0);
         if (rsp0_valid_o && rsp0_ready_i) popCheck(1'b0);
         if (rsp1_valid_o && rsp1_ready_i) popCheck(1'b1);
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req0_ready"}, req0_ready_o, 0);
      checkOutput({tag, "_req1_ready"}, req1_ready_o, 0);
      checkOutput({tag, "_rsp0_valid"}, rsp0_valid_o, 0);
      checkOutput({tag, "_rsp1_valid"}, rsp1_valid_o, 0);
      checkOutput({tag, "_rsp_data"}, rsp_data_o, 0);
      checkOutput({tag, "_rsp_err"}, rsp_err_o, 0);
      checkOutput({tag, "_cipher_req"}, cipher_req_o, 0);
      checkOutput({tag, "_cipher_ack"}, cipher_ack_o, 0);
      checkOutput({tag, "_cipher_data"}, cipher_data_o, 0);
      checkOutput({tag, "_busy"}, busy_o, 0);
      checkOutput({tag, "_owner"}, owner_o, 0);
   endtask

   task automatic doReset();
      rstn_i = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
   endtask

   task automatic clearStats();
      served_q.delete();
      req_pulses = 0; ack_pulses = 0; rsp1_seen = 1'b0;
   endtask

   task automatic waitGrant(input logic which, input string tag, output int hs_cyc);
      logic got = 1'b0;
      hs_cyc = -1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk_i);
         if (which ? req1_ready_o : req0_ready_o) begin
            got = 1'b1;
            hs_cyc = cyc;
         end
         @(posedge clk_i); #1;
      end
      checkOutput({tag, "_grant_seen"}, got, 1);
   endtask

   task automatic waitDone(input string tag);
      logic ok = 1'b0;
      for (int k = 0; k < 600 && !ok; k++) begin
         if (!busy_o && sb.size() == 0) ok = 1'b1;
         else begin @(posedge clk_i); #1; end
      end
      checkOutput({tag, "_done"}, ok, 1);
   endtask

   // Offer n0/n1 blocks from each requester and run until all responses drain
   task automatic applyStimulus(input int n0, input logic [127:0] d0, input int n1,
                                input logic [127:0] d1, input logic exp_first, input string tag);
      int   rem0 = n0, rem1 = n1, used = 0;
      logic first_seen = 1'b0, hs0, hs1;
      logic [127:0] cur0 = d0, cur1 = d1;
      req0_valid_i = (rem0 > 0); req0_data_i = cur0;
      req1_valid_i = (rem1 > 0); req1_data_i = cur1;
      while ((rem0 > 0 || rem1 > 0 || busy_o || sb.size() > 0) && used < 800) begin
         @(negedge clk_i);
         hs0 = req0_valid_i && req0_ready_o;
         hs1 = req1_valid_i && req1_ready_o;
         if (!first_seen && (hs0 || hs1)) begin
            first_seen = 1'b1;
            checkOutput({tag, "_first_owner"}, hs1, exp_first);
         end
         @(posedge clk_i); #1;
         used++;
         if (hs0) begin rem0--; cur0 = cur0 + 1; req0_data_i = cur0; req0_valid_i = (rem0 > 0); end
         if (hs1) begin rem1--; cur1 = cur1 + 1; req1_data_i = cur1; req1_valid_i = (rem1 > 0); end
      end
      checkOutput({tag, "_in_budget"}, used < 800, 1);
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
   endtask

   typedef struct {
      int           n0;
      int           n1;
      int           lat;
      logic [3:0]   order;
      logic [127:0] d0;
      logic [127:0] d1;
   } vec_t;

   vec_t vecs[8];

   // Hard stop in case the run wedges somewhere unexpected
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got hang expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int t_hs, g_cyc, r_cyc;
      logic [127:0] exp_bp;
      logic stall_bad;
      string tag;

      vecs[0] = '{2, 2, 3, 4'b1010, '0, '0};
      vecs[1] = '{0, 1, 1, 4'b0001, '0, '0};
      vecs[2] = '{1, 0, 5, 4'b0000, '0, '0};
      vecs[3] = '{1, 1, 2, 4'b0001, '0, '0};
      vecs[4] = '{1, 0, 1, 4'b0000, '0, '0};
      vecs[5] = '{1, 1, 3, 4'b0001, '0, '0};
      vecs[6] = '{0, 1, 2, 4'b0001, '0, '0};
      vecs[7] = '{1, 1, 1, 4'b0010, '0, '0};
      for (int i = 0; i < 8; i++) begin
         vecs[i].d0 = {32'(i), 96'h0a0b0c0d_11223344_55667788};
         vecs[i].d1 = {32'(i + 100), 96'hdeadbeef_cafef00d_01234567};
      end

      // Reset values while reset is held
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkResetValues("rst");
      @(posedge clk_i); #1 rstn_i = 1'b1;

      // Single block with the standard vector
      clearStats();
      stub_lat = 3;
      applyStimulus(1, PT, 0, '0, 1'b0, "single");
      checkOutput("single_ct", last_rsp_data, CT);
      checkOutput("single_req_pulses", req_pulses, 1);
      checkOutput("single_ack_pulses", ack_pulses, 1);
      checkOutput("single_rsp1_never", rsp1_seen, 0);

      // Latency: handshake T -> req T+1, rsp T+5, ack T+6, next grant T+7
      stub_lat = 3;
      req0_valid_i = 1'b1; req0_data_i = PT + 5;
      waitGrant(1'b0, "lat0", t_hs);
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b1; req1_data_i = PT + 9;
      waitGrant(1'b1, "lat1", g_cyc);
      req1_valid_i = 1'b0;
      checkOutput("lat_req_pulse", last_req_cyc, t_hs + 1);
      checkOutput("lat_rsp_valid", rsp_rise_cyc, t_hs + 5);
      checkOutput("lat_ack", last_ack_cyc, t_hs + 6);
      checkOutput("lat_next_grant", g_cyc, t_hs + 7);
      waitDone("lat");

      // Round-robin vector table, starting from a fresh reset
      doReset();
      for (int i = 0; i < 8; i++) begin
         tag = $sformatf("vec%0d", i);
         clearStats();
         stub_lat = vecs[i].lat;
         applyStimulus(vecs[i].n0, vecs[i].d0, vecs[i].n1, vecs[i].d1, vecs[i].order[0], tag);
         checkOutput({tag, "_count"}, served_q.size(), vecs[i].n0 + vecs[i].n1);
         for (int j = 0; j < served_q.size() && j < 4; j++)
            checkOutput($sformatf("%s_order%0d", tag, j), served_q[j], vecs[i].order[j]);
      end

      // Response backpressure on requester 1 with requester 0 waiting
      clearStats();
      stub_lat = 2;
      rsp1_ready_i = 1'b0;
      req1_valid_i = 1'b1; req1_data_i = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      exp_bp = coreModel(req1_data_i);
      waitGrant(1'b1, "bp", t_hs);
      req1_valid_i = 1'b0;
      for (int k = 0; k < 50 && !rsp1_valid_o; k++) begin @(posedge clk_i); #1; end
      req0_valid_i = 1'b1; req0_data_i = 128'h5555;
      stall_bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (!rsp1_valid_o || rsp_data_o !== exp_bp || cipher_ack_o || req0_ready_o) stall_bad = 1'b1;
         @(posedge clk_i); #1;
      end
      checkOutput("bp_stall_stable", stall_bad, 0);
      checkOutput("bp_stall_data", rsp_data_o, exp_bp);
      checkOutput("bp_no_ack", ack_pulses, 0);
      rsp1_ready_i = 1'b1;
      @(negedge clk_i); r_cyc = cyc;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checkOutput("bp_ack_after_ready", cipher_ack_o, 1);
      checkOutput("bp_ack_cycle", cyc, r_cyc + 1);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checkOutput("bp_next_grant", req0_ready_o, 1);
      @(posedge clk_i); #1;
      req0_valid_i = 1'b0;
      waitDone("bp");

      // Asynchronous reset while waiting on the core, then recovery
      stub_lat = 40;
      req0_valid_i = 1'b1; req0_data_i = PT;
      waitGrant(1'b0, "mid", t_hs);
      req0_valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #2 rstn_i = 1'b0;
      #1 checkResetValues("midrst");
      sb.delete();
      @(posedge clk_i); #1 rstn_i = 1'b1;
      clearStats();
      stub_lat = 2;
      applyStimulus(1, PT, 0, '0, 1'b0, "after_rst");
      checkOutput("after_rst_ct", last_rsp_data, CT);

      // Core that never answers
      clearStats();
      stub_never = 1'b1;
      req0_valid_i = 1'b1; req0_data_i = PT;
      waitGrant(1'b0, "to", t_hs);
      req0_valid_i = 1'b0;
`ifdef KUZNECHIK_ARB_TIMEOUT_EN
      waitDone("to");
      checkOutput("to_rsp_delay", rsp_rise_cyc - last_req_cyc, TO_CYCLES + 1);
      checkOutput("to_ack_pulses", ack_pulses, 1);
      checkOutput("to_err_seen", served_q.size(), 1);
`else
      stall_bad = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk_i);
         if (!busy_o || rsp0_valid_o || rsp1_valid_o || cipher_ack_o) stall_bad = 1'b1;
      end
      checkOutput("to_unbounded_wait", stall_bad, 0);
      checkOutput("to_no_ack", ack_pulses, 0);
      @(posedge clk_i); #1;
      doReset();
`endif
      stub_never = 1'b0;

      checkOutput("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kuznechik_cipher_arbiter.md
# kuznechik_cipher_arbiter

Round-robin scheduler that shares one `kuznechik_cipher` core between two independent 128-bit block requesters. It owns the core's request/ack handshake and latches the plaintext and ciphertext, so neither requester touches the core directly. It returns each result only to the requester that issued it. It sits between the core and two clients, e.g. the APB register wrapper and a DMA-fed stream port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles, applied while waiting for the core. Used only with `KUZNECHIK_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `req0_valid_i` / `req1_valid_i` in 1: requester N offers a block.
- `req0_data_i` / `req1_data_i` in 128: plaintext block.
- `req0_ready_o` / `req1_ready_o` out 1: block accepted when valid & ready.
- `rsp0_valid_o` / `rsp1_valid_o` out 1: result available to requester N.
- `rsp0_ready_i` / `rsp1_ready_i` in 1: requester N takes the result.
- `rsp_data_o` out 128: ciphertext, shared; qualified by `rspN_valid_o`.
- `rsp_err_o` out 1: result is a timeout error; qualified by `rspN_valid_o`.
- `cipher_req_o` out 1: one-cycle start pulse to the core (`request_i`).
- `cipher_ack_o` out 1: one-cycle acknowledge to the core (`ack_i`).
- `cipher_data_o` out 128: core `data_i`.
- `cipher_busy_i` in 1: core `busy_o`.
- `cipher_valid_i` in 1: core `valid_o`, held until ack.
- `cipher_data_i` in 128: core `data_o`.
- `busy_o` out 1: arbiter state is not IDLE.
- `owner_o` out 1: index of the requester currently served.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, ACK.
- **IDLE**
  - If exactly one `reqN_valid_i` is high, grant N.
  - If both are high, grant the requester not served last. The last-served pointer resets so that requester 0 wins the first tie.
  - `reqN_ready_o` is driven combinationally, high only for the granted N and only in IDLE.
  - On handshake: latch data into `blk_q`, set owner = N, go to ISSUE.
- **ISSUE**: `cipher_req_o`=1 for exactly one cycle; go to WAIT. `cipher_data_o` = `blk_q`, held stable from ISSUE through ACK. Outside those states it is 0.
- **WAIT**
  - Stay until `cipher_valid_i`=1.
  - Then latch `cipher_data_i` into `res_q`, clear the error flag, go to RESP.
  - `cipher_busy_i` is informational only and does not affect transitions.
- **RESP**
  - `rsp<owner>_valid_o`=1; the other requester's `rsp_valid` stays 0.
  - `rsp_data_o` = `res_q`; it is 0 whenever neither `rsp_valid` is high.
  - Hold until `rsp<owner>_ready_i`=1, then update the last-served pointer to owner and go to ACK.
- **ACK**: `cipher_ack_o`=1 for one cycle; go to IDLE.
- **Requester handshakes**
  - A requester may keep `req_valid` high while its previous response is pending. It is not granted again until the FSM returns to IDLE.
  - `rsp_ready` outside RESP for that owner is ignored.
- **Reset**: asserting `rstn_i` mid-operation forces IDLE immediately. The core must be reset alongside it by the integrator.

## Timing
- Reset values:
  - all `ready_o`/`valid_o` = 0
  - `cipher_req_o` = 0, `cipher_ack_o` = 0
  - `cipher_data_o` = 0, `rsp_data_o` = 0
  - `rsp_err_o` = 0, `busy_o` = 0, `owner_o` = 0
  - `blk_q` = 0, `res_q` = 0
  - last-served pointer = 1
- Latency:
  - Request handshake at cycle T gives `cipher_req_o` at T+1.
  - `cipher_valid_i` first seen high at cycle V gives `rsp_valid` at V+1.
  - `rsp_ready` accepted at cycle R gives `cipher_ack_o` at R+1 and IDLE at R+2, so the next grant can occur at R+2.
- Minimum overhead per block beyond core latency: 4 cycles.

## Configuration
- `KUZNECHIK_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT, starting from 0 on entry.
  - If it reaches `TIMEOUT_CYCLES`-1 with `cipher_valid_i` still 0, the FSM goes to RESP with `rsp_err_o`=1 and `res_q`=0, then ACK, then IDLE as normal.
  - If `cipher_valid_i` arrives in the same cycle as the limit, valid wins and no error is flagged.
- Macro undefined: no counter; WAIT is unbounded; `rsp_err_o` is tied to 0.

## Test plan
- **Single block**: requester 0 sends `1122334455667700ffeeddccbbaa9988` to the real core (standard key).
  - `rsp0_valid_o` with `7f679d90bebc24305a468d42b9d4edcd`, `rsp_err_o`=0.
  - One `cipher_req_o` pulse and one `cipher_ack_o` pulse.
  - `rsp1_valid_o` never asserted.
- **Tie after reset**: both valid in the same cycle after reset.
  - Order of service: requester 0, then requester 1, then 0 again (both held valid for 3 blocks).
- **Response backpressure**: hold `rsp1_ready_i`=0 for 20 cycles.
  - `rsp1_valid_o` and `rsp_data_o` remain stable.
  - No `cipher_ack_o` until the cycle after ready.
  - No new grant during the stall.
- **Reset mid-operation**: pulse `rstn_i` low during WAIT.
  - All outputs return to reset values asynchronously.
  - A subsequent request completes correctly.
- **Timeout** (`TIMEOUT_CYCLES`=8, macro defined): stub core never asserts valid.
  - `rsp0_valid_o` with `rsp_err_o`=1 and data 0 exactly 9 cycles after `cipher_req_o`, i.e. 8 WAIT cycles then RESP.
  - Then one `cipher_ack_o` pulse.
  - Without the macro, the FSM stays in WAIT for 1000 cycles.
- **Latency check**: stub core asserts valid 3 cycles after the request.
  - Handshake at T gives `rsp_valid` at T+5 (with `rsp_ready` held high).
  - Next grant possible at T+7.
